// File: rtl/ifft_bfp_scale_ctrl.sv
// Block-floating-point shift scheduler: tracks per-frame headroom and issues the next frame's right-shift.
// Optional SCALE_FORCE_EN adds cfg_force/cfg_shift to override the computed shift.
//
// state   | meaning
// S_IDLE  | no frame in progress, waiting for sample 0
// S_ACCUM | collecting samples, tracking minimum headroom
// S_LATCH | frame complete; shift and exponent update, may accept next sample 0
module ifft_bfp_scale_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int NFFT       = 128,
   parameter int GUARD_BITS = 2,
   parameter int EXP_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     data_in_r,
   input  logic [DATA_WIDTH-1:0]     data_in_i,
   input  logic                      exp_clr,
`ifdef SCALE_FORCE_EN
   input  logic                      cfg_force,
   input  logic [$clog2(NFFT):0]     cfg_shift,
`endif
   output logic [$clog2(NFFT):0]     shift_mag,
   output logic                      shift_valid,
   output logic [EXP_WIDTH-1:0]      block_exp,
   output logic [$clog2(NFFT)-1:0]   frame_cnt_o,
   output logic                      busy
);

   localparam int SW   = $clog2(NFFT) + 1;
   localparam int CW   = $clog2(NFFT);
   localparam int HW   = $clog2(DATA_WIDTH);
   localparam int SMAX = (1 << SW) - 1;
   localparam int SUMW = ((EXP_WIDTH > SW) ? EXP_WIDTH : SW) + 1;
   localparam logic [HW-1:0]        HR_MAX  = HW'(DATA_WIDTH - 1);
   localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
   localparam logic [CW-1:0]        CNT_END = CW'(NFFT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LATCH} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [HW-1:0]        hr_min, hr_min_nxt;
   logic [HW-1:0]        hr_r, hr_i, hr_smp, hr_acc;
   logic [SW-1:0]        shift_nxt, shift_calc, shift_sel;
   logic                 valid_nxt;
   logic [EXP_WIDTH-1:0] exp_nxt, exp_base;
   logic [SUMW-1:0]      exp_sum;
   int                   shift_d;

   // Redundant sign bits: leading bits matching the MSB, excluding the MSB itself.
   function automatic logic [HW-1:0] headroom(input logic [DATA_WIDTH-1:0] x);
      logic [HW-1:0] n;
      logic          run;
      n   = '0;
      run = 1'b1;
      for (int b = DATA_WIDTH - 2; b >= 0; b--) begin
         if (run && (x[b] == x[DATA_WIDTH-1])) n = n + HW'(1);
         else                                  run = 1'b0;
      end
      return n;
   endfunction

   always_comb begin
      hr_r   = headroom(data_in_r);
      hr_i   = headroom(data_in_i);
      hr_smp = (hr_r < hr_i) ? hr_r : hr_i;
      hr_acc = (hr_smp < hr_min) ? hr_smp : hr_min;
   end

   always_comb begin
      shift_d = 0;
      if (int'(hr_min) < GUARD_BITS) shift_d = GUARD_BITS - int'(hr_min);
      if (shift_d > SMAX)            shift_d = SMAX;
      shift_calc = SW'(shift_d);
`ifdef SCALE_FORCE_EN
      shift_sel = cfg_force ? cfg_shift : shift_calc;
`else
      shift_sel = shift_calc;
`endif
   end

   // Clear takes effect before the LATCH add, so a coincident clear leaves only the new shift.
   always_comb begin
      exp_base = exp_clr ? '0 : block_exp;
      exp_sum  = SUMW'(exp_base) + SUMW'(shift_sel);
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hr_min_nxt = hr_min;
      shift_nxt  = shift_mag;
      valid_nxt  = 1'b0;
      exp_nxt    = exp_base;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt  = S_ACCUM;
               cnt_nxt    = CW'(1);
               hr_min_nxt = hr_smp;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               hr_min_nxt = hr_acc;
               if (cnt == CNT_END) begin
                  cnt_nxt   = '0;
                  state_nxt = S_LATCH;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         S_LATCH: begin
            shift_nxt = shift_sel;
            valid_nxt = 1'b1;
            exp_nxt   = (exp_sum > SUMW'(EXP_MAX)) ? EXP_MAX : EXP_WIDTH'(exp_sum);
            if (in_valid) begin
               hr_min_nxt = hr_smp;
               cnt_nxt    = CW'(1);
               state_nxt  = S_ACCUM;
            end else begin
               hr_min_nxt = HR_MAX;
               state_nxt  = S_IDLE;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            hr_min_nxt = HR_MAX;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         hr_min      <= HR_MAX;
         shift_mag   <= '0;
         shift_valid <= 1'b0;
         block_exp   <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         hr_min      <= hr_min_nxt;
         shift_mag   <= shift_nxt;
         shift_valid <= valid_nxt;
         block_exp   <= exp_nxt;
      end
   end

   assign frame_cnt_o = cnt;
   assign busy        = (cnt != '0);

endmodule

// File: tb/tb_ifft_bfp_scale_ctrl.sv
// Self-checking bench for ifft_bfp_scale_ctrl: directed frames plus random traffic against a frame-level model.
module tb_ifft_bfp_scale_ctrl;

   localparam int DW   = 16;
   localparam int N    = 8;
   localparam int G    = 2;
   localparam int EW   = 8;
   localparam int EW2  = 2;
   localparam int SW   = $clog2(N) + 1;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] dr = '0;
   logic [DW-1:0] di = '0;
   logic          exp_clr = 1'b0;

   logic [SW-1:0] sm0, sm1;
   logic          sv0, sv1;
   logic [EW-1:0] be0;
   logic [EW2-1:0] be1;
   logic [SW-2:0] fc0, fc1;
   logic          bz0, bz1;

   int n_chk = 0;
   int n_err = 0;

   ifft_bfp_scale_ctrl #(.DATA_WIDTH(DW), .NFFT(N), .GUARD_BITS(G), .EXP_WIDTH(EW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in_r(dr), .data_in_i(di),
      .exp_clr(exp_clr), .shift_mag(sm0), .shift_valid(sv0), .block_exp(be0),
      .frame_cnt_o(fc0), .busy(bz0));

   ifft_bfp_scale_ctrl #(.DATA_WIDTH(DW), .NFFT(N), .GUARD_BITS(G), .EXP_WIDTH(EW2)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in_r(dr), .data_in_i(di),
      .exp_clr(exp_clr), .shift_mag(sm1), .shift_valid(sv1), .block_exp(be1),
      .frame_cnt_o(fc1), .busy(bz1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Headroom as the largest k with -2^(DW-1-k) <= x < 2^(DW-1-k).
   function automatic int hr_ref(input logic [DW-1:0] x);
      int v;
      int lim;
      v = int'($signed(x));
      for (int k = DW - 1; k >= 0; k--) begin
         lim = 1 << (DW - 1 - k);
         if (v >= -lim && v < lim) return k;
      end
      return 0;
   endfunction

   int m_hr[$];
   int m_cnt = 0, m_shift = 0, m_valid = 0, m_be = 0, m_be2 = 0;
   int m_pend = 0, m_pend_shift = 0, m_pulses = 0, dut_pulses = 0;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_step();
      int mn;
      if (rst) begin
         m_hr.delete();
         m_cnt = 0; m_shift = 0; m_valid = 0; m_be = 0; m_be2 = 0; m_pend = 0;
         return;
      end
      m_valid = 0;
      if (m_pend != 0) begin
         m_shift = m_pend_shift;
         m_valid = 1;
         m_be    = sat((exp_clr ? 0 : m_be) + m_shift, (1 << EW) - 1);
         m_be2   = sat((exp_clr ? 0 : m_be2) + m_shift, (1 << EW2) - 1);
         m_pend  = 0;
         m_pulses++;
      end else if (exp_clr) begin
         m_be  = 0;
         m_be2 = 0;
      end
      if (in_valid) begin
         m_hr.push_back(hr_ref(dr));
         m_hr.push_back(hr_ref(di));
         m_cnt++;
         if (m_cnt == N) begin
            mn = DW - 1;
            foreach (m_hr[j]) if (m_hr[j] < mn) mn = m_hr[j];
            m_pend_shift = sat((mn < G) ? G - mn : 0, SMAX);
            m_pend = 1;
            m_hr.delete();
            m_cnt = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("shift_mag", int'(sm0), m_shift);
      chk("shift_valid", int'(sv0), m_valid);
      chk("block_exp", int'(be0), m_be);
      chk("frame_cnt", int'(fc0), m_cnt);
      chk("busy", int'(bz0), (m_cnt != 0) ? 1 : 0);
      chk("block_exp_sat", int'(be1), m_be2);
      if (sv0) dut_pulses++;
   end

   task automatic drive(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i, input logic c);
      in_valid = v;
      dr       = r;
      di       = i;
      exp_clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_latch(input string tag, input int sm, input int be);
      chk({tag, "_valid"}, int'(sv0), 1);
      chk({tag, "_shift"}, int'(sm0), sm);
      chk({tag, "_bexp"}, int'(be0), be);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_shift"}, int'(sm0), 0);
      chk({tag, "_valid"}, int'(sv0), 0);
      chk({tag, "_bexp"}, int'(be0), 0);
      chk({tag, "_cnt"}, int'(fc0), 0);
      chk({tag, "_busy"}, int'(bz0), 0);
   endtask

   initial begin
      logic [DW-1:0] t_r, t_i;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      for (int k = 0; k < N; k++) drive(1'b1, 16'h0000, 16'h0000, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("zeros", 0, 0);

      drive(1'b1, 16'h4000, 16'h0100, 1'b0);
      for (int k = 1; k < N; k++) drive(1'b1, 16'h0100, 16'h0100, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("peak4000", 2, 2);
      drive(1'b1, 16'h2000, 16'h0000, 1'b0);
      for (int k = 1; k < N; k++) drive(1'b1, 16'h0000, 16'h0000, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("peak2000", 1, 3);

      for (int k = 0; k < N; k++) begin
         drive(1'b1, 16'h0100, (k == 3) ? 16'h8000 : 16'h0100, 1'b0);
         if (k < N - 1) begin
            repeat (3) drive(1'b0, '0, '0, 1'b0);
            chk("gap_cnt", int'(fc0), k + 1);
         end
      end
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("gaps", 2, 5);

      for (int k = 0; k < 2 * N; k++) begin
         t_r = (k == 2) ? 16'h1000 : ((k == 12) ? 16'h4000 : 16'h0080);
         drive(1'b1, t_r, 16'h0080, 1'b0);
         if (k == N) begin
            expect_latch("b2b_first", 0, 5);
            chk("b2b_cnt", int'(fc0), 1);
         end
      end
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("b2b_second", 2, 7);

      for (int f = 0; f < 3; f++) begin
         drive(1'b1, 16'h8000, 16'h0000, 1'b0);
         for (int k = 1; k < N; k++) drive(1'b1, 16'h0000, 16'h0000, 1'b0);
         drive(1'b0, '0, '0, (f == 0) ? 1'b1 : 1'b0);
         expect_latch("clr_frame", 2 , 2 + 2 * f);
         chk("sat_bexp", int'(be1), (f == 0) ? 2 : 3);
      end
      drive(1'b0, '0, '0, 1'b1);
      chk("clr_only", int'(be0), 0);

      for (int k = 0; k < 5; k++) drive(1'b1, 16'h4000, 16'h4000, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < N; k++) drive(1'b1, 16'h0001, 16'h0001, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      expect_latch("post_rst", 0, 0);
      drive(1'b0, '0, '0, 1'b0);
      chk("post_rst_single", int'(sv0), 0);

      for (int f = 0; f < 40; f++) begin
         for (int s = 0; s < N; s++) begin
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 3)) drive(1'b0, '0, '0, ($urandom_range(0, 9) == 0));
            t_r = DW'($signed(DW'($urandom)) >>> $urandom_range(0, DW - 1));
            t_i = DW'($signed(DW'($urandom)) >>> $urandom_range(0, DW - 1));
            drive(1'b1, t_r, t_i, ($urandom_range(0, 9) == 0));
         end
         repeat ($urandom_range(0, 2)) drive(1'b0, '0, '0, ($urandom_range(0, 9) == 0));
      end
      repeat (3) drive(1'b0, '0, '0, 1'b0);

      chk("pulse_count", dut_pulses, m_pulses);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ifft_bfp_scale_ctrl.md
Name: ifft_bfp_scale_ctrl

Overview:
Block-floating-point scaling scheduler for the SDF IFFT datapath.
- Monitors each NFFT-sample complex frame entering a stage and finds the worst-case headroom.
- At end of frame, decides the arithmetic right-shift magnitude to apply to the next frame, and drives the complex right-shift unit's shift-magnitude input.
- Keeps a running block exponent so the cross-correlation back end can renormalise.

Parameters:
DATA_WIDTH, 16, width of each real/imag sample (two's complement)
NFFT, 128, samples per frame; power of two, >= 2
GUARD_BITS, 2, minimum headroom (redundant sign bits) required before the next stage
EXP_WIDTH, 8, width of the accumulated block exponent

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  sample qualifier; no backpressure
data_in_r  input  DATA_WIDTH  signed real sample
data_in_i  input  DATA_WIDTH  signed imag sample
exp_clr  input  1  synchronous clear of block exponent
shift_mag  output  $clog2(NFFT)+1  shift for next frame, held between updates
shift_valid  output  1  one-cycle pulse when shift_mag updates
block_exp  output  EXP_WIDTH  unsigned sum of all issued shifts, saturating
frame_cnt_o  output  $clog2(NFFT)  current sample index in frame
busy  output  1  high while a frame is partially received

Behaviour:
- Reset (async, rst=1): shift_mag=0, shift_valid=0, block_exp=0, frame_cnt_o=0, busy=0, headroom tracker=DATA_WIDTH-1, FSM=IDLE.
- Headroom of x: number of leading bits equal to the sign bit, minus 1. Range 0..DATA_WIDTH-1. 0 and -1 give DATA_WIDTH-1; 16'h4000 and 16'h8000 give 0.
- Per accepted sample: hr_min <= min(hr_min, hr(r), hr(i)).
- FSM IDLE: in_valid -> ACCUM, count=1, and the tracker is seeded with this sample.
- FSM ACCUM: each in_valid increments the count. in_valid=0 cycles are gaps: state and count are held.
- End of frame: on the in_valid that is the NFFT-th sample, the FSM goes to LATCH.
- FSM LATCH (single cycle):
  - shift_mag <= (hr_min < GUARD_BITS) ? GUARD_BITS-hr_min : 0, using hr_min including the final sample.
  - Result saturates at $clog2(NFFT)+1's max.
  - shift_valid=1.
  - block_exp <= min(block_exp+shift, 2^EXP_WIDTH-1).
  - Tracker reset to DATA_WIDTH-1.
- Same-cycle events in LATCH:
  - in_valid in LATCH is sample 0 of the next frame. It is accepted, seeds the tracker (overriding reset), sets count=1, and the FSM goes to ACCUM. Otherwise the FSM goes to IDLE.
  - Net latency: the last sample's edge plus 1 cycle to shift_valid. Back-to-back frames with no gap lose no samples.
- Counter: frame_cnt_o wraps NFFT-1 -> 0. busy=1 whenever count != 0.
- exp_clr: block_exp <= 0. If it coincides with LATCH, block_exp <= new shift (clear first, then add).
- Reset mid-frame: partial frame discarded, no shift_valid is emitted, and the first post-reset sample starts a new frame.
- shift_mag never changes except in LATCH or on reset.

Optional Feature:
SCALE_FORCE_EN
- Defined: adds ports cfg_force (in, 1) and cfg_shift (in, $clog2(NFFT)+1).
  - When cfg_force=1 at LATCH, shift_mag <= cfg_shift instead of the computed value.
  - block_exp accumulates cfg_shift, and the headroom tracking still runs.
- Undefined: ports absent; the computed shift is always used.

Test Plan:
- DATA_WIDTH=16, NFFT=8, GUARD=2; frame of all zeros -> shift_valid pulse 1 cycle after 8th sample, shift_mag=0, block_exp=0.
- Frame with one sample r=16'h4000, rest 16'h0100 -> shift_mag=2, block_exp=2. Next frame peak 16'h2000 -> shift_mag=1, block_exp=3.
- Frame with i=16'h8000 (-32768) and 3-cycle in_valid gaps -> shift_mag=2, frame_cnt_o holds during gaps, no extra shift_valid.
- Two frames back-to-back (in_valid continuously 16 cycles): first peak 16'h1000, second peak 16'h4000 -> shift_mag 0 then 2, exactly two pulses 8 cycles apart, no sample lost.
- EXP_WIDTH=2, four frames each needing shift 2 -> block_exp 2,3,3,3. exp_clr asserted in same cycle as a shift_valid pulse -> block_exp=2.
- rst asserted after 5 samples of a frame -> all outputs 0 immediately; then 8 samples of 16'h0001 -> single shift_valid, shift_mag=0.
